// File: rtl/hack_cpu_ctrl_if.sv
// Bus bundle between the Hack CPU sequencer and its instruction memory, data memory and ALU.
// The master modport is the CPU side; the slave modport is the memory/ALU side.
interface hack_cpu_ctrl_if;
  logic        imem_req;
  logic [14:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [14:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata,
    output alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
    input  alu_out, alu_zr, alu_ng
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata,
    input  alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
    output alu_out, alu_zr, alu_ng
  );
endinterface

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU sequencer: fetch/decode/memory/execute/writeback over an external ALU.
// Owns A, D and PC; memory accesses use a hold-until-ack request handshake.
module hack_cpu_ctrl #(
  parameter logic [14:0] RESET_PC = 15'd0
) (
  input  logic            clk,
  input  logic            rst_n,
  hack_cpu_ctrl_if.master hack_bus,
  output logic [14:0]     pc,
  output logic [15:0]     a_reg,
  output logic [15:0]     d_reg,
  output logic            instr_done
);

  typedef enum logic [2:0] {FETCH, DECODE, MEMRD, EXEC, WB} state_t;

  state_t      state_q, state_d;
  logic [14:0] pc_q, pc_d;
  logic [15:0] a_q, a_d;
  logic [15:0] d_q, d_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] m_q, m_d;
  logic [15:0] res_q, res_d;
  logic        zr_q, zr_d;
  logic        ng_q, ng_d;
  logic        done_q, done_d;
  logic        imem_req_c, dmem_req_c, dmem_we_c;
  logic        jump;

  assign jump = (ir_q[2] & ng_q) | (ir_q[1] & zr_q) | (ir_q[0] & ~ng_q & ~zr_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      a_q     <= '0;
      d_q     <= '0;
      ir_q    <= '0;
      m_q     <= '0;
      res_q   <= '0;
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      d_q     <= d_d;
      ir_q    <= ir_d;
      m_q     <= m_d;
      res_q   <= res_d;
      zr_q    <= zr_d;
      ng_q    <= ng_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    a_d        = a_q;
    d_d        = d_q;
    ir_d       = ir_q;
    m_d        = m_q;
    res_d      = res_q;
    zr_d       = zr_q;
    ng_d       = ng_q;
    done_d     = 1'b0;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req_c = 1'b1;
        if (hack_bus.imem_ack) begin
          ir_d    = hack_bus.imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (!ir_q[15]) begin
          a_d     = {1'b0, ir_q[14:0]};
          pc_d    = pc_q + 15'd1;
          done_d  = 1'b1;
          state_d = FETCH;
        end else if (ir_q[12]) begin
          state_d = MEMRD;
        end else begin
          state_d = EXEC;
        end
      end
      MEMRD: begin
        dmem_req_c = 1'b1;
        if (hack_bus.dmem_ack) begin
          m_d     = hack_bus.dmem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = hack_bus.alu_out;
        zr_d    = hack_bus.alu_zr;
        ng_d    = hack_bus.alu_ng;
        state_d = WB;
      end
      WB: begin
        dmem_req_c = ir_q[3];
        dmem_we_c  = ir_q[3];
        // A is still the pre-instruction value here, so it serves as both store address and jump target.
        if (!ir_q[3] || hack_bus.dmem_ack) begin
          if (ir_q[5]) a_d = res_q;
          if (ir_q[4]) d_d = res_q;
          pc_d    = jump ? a_q[14:0] : pc_q + 15'd1;
          done_d  = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign hack_bus.imem_req   = imem_req_c & rst_n;
  assign hack_bus.imem_addr  = pc_q;
  assign hack_bus.dmem_req   = dmem_req_c & rst_n;
  assign hack_bus.dmem_we    = dmem_we_c;
  assign hack_bus.dmem_addr  = a_q[14:0];
  assign hack_bus.dmem_wdata = res_q;
  assign hack_bus.alu_x      = d_q;
  assign hack_bus.alu_y      = ir_q[12] ? m_q : a_q;
  assign hack_bus.alu_zx     = ir_q[11];
  assign hack_bus.alu_nx     = ir_q[10];
  assign hack_bus.alu_zy     = ir_q[9];
  assign hack_bus.alu_ny     = ir_q[8];
  assign hack_bus.alu_f      = ir_q[7];
  assign hack_bus.alu_no     = ir_q[6];

  assign pc         = pc_q;
  assign a_reg      = a_q;
  assign d_reg      = d_q;
  assign instr_done = done_q;

endmodule
